// File: rtl/skid_buffer_stage.sv
// Two-entry valid/ready skid buffer with fully registered up_ready/dn_valid/dn_data.
// Optional back-pressure statistics counter enabled by defining SKID_STATS_EN.

module skid_buffer_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             up_ready,
  output logic             dn_valid,
  output logic [WIDTH-1:0] dn_data,
  input  logic             dn_ready,
  output logic [15:0]      stall_cnt
);

  // state | meaning
  // EMPTY | no word held; dn_valid=0, up_ready=1
  // BUSY  | one word in main; dn_valid=1, up_ready=1
  // FULL  | main and skid both held; dn_valid=1, up_ready=0
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             dn_valid_q, dn_valid_d;
  logic             up_ready_q, up_ready_d;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (up_valid) begin
          main_d  = up_data;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (up_valid && dn_ready) begin
          main_d = up_data;
        end else if (up_valid) begin
          skid_d  = up_data;
          state_d = ST_FULL;
        end else if (dn_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (dn_ready) begin
          main_d  = skid_q;
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Handshake flops are loaded from the next state so outputs never see inputs.
    dn_valid_d = (state_d == ST_BUSY) || (state_d == ST_FULL);
    up_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      dn_valid_q <= 1'b0;
      up_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      dn_valid_q <= dn_valid_d;
      up_ready_q <= up_ready_d;
    end
  end

  assign up_ready = up_ready_q;
  assign dn_valid = dn_valid_q;
  assign dn_data  = main_q;

`ifdef SKID_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (dn_valid_q && !dn_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_skid_buffer_stage.sv
// Scoreboard bench for skid_buffer_stage: the reference is a 2-deep FIFO occupancy model,
// run on a WIDTH=8 instance and a WIDTH=1 instance sharing the same handshake stimulus.

module tb_skid_buffer_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        up_valid = 1'b0;
  logic [7:0]  up_data = 8'h00;
  logic        dn_ready = 1'b0;

  logic        up_ready, dn_valid;
  logic [7:0]  dn_data;
  logic [15:0] stall_cnt;
  logic        up_ready1, dn_valid1;
  logic [0:0]  dn_data1;
  logic [15:0] stall_cnt1;

  always #5 clk = ~clk;

  skid_buffer_stage #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_data(up_data), .up_ready(up_ready),
    .dn_valid(dn_valid), .dn_data(dn_data), .dn_ready(dn_ready),
    .stall_cnt(stall_cnt)
  );

  skid_buffer_stage #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .up_valid(up_valid), .up_data(up_data[0:0]), .up_ready(up_ready1),
    .dn_valid(dn_valid1), .dn_data(dn_data1), .dn_ready(dn_ready),
    .stall_cnt(stall_cnt1)
  );

  // Reference: words held by the buffer, oldest first; at most two.
  logic [7:0]  exp_q[$];
  logic [7:0]  last_out = 8'h00;
  logic [7:0]  pend_data = 8'h00;
  bit          accept_pend = 1'b0;
  int unsigned stall_exp = 0;
  int          n_out = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] stall_model();
`ifdef SKID_STATS_EN
    return stall_exp;
`else
    return 32'd0;
`endif
  endfunction

  // One stimulus cycle: record the word accepted at the edge just passed, then drive new inputs.
  task automatic cycle(input bit v, input logic [7:0] d, input bit r, output bit acc);
    @(posedge clk);
    if (accept_pend) exp_q.push_back(pend_data);
    #1;
    up_valid = v;
    up_data  = d;
    dn_ready = r;
    acc = v && (exp_q.size() < 2);
    accept_pend = acc;
    pend_data = d;
  endtask

  task automatic idle(input int n, input bit r);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, r, acc);
  endtask

  task automatic clear_model();
    exp_q.delete();
    last_out = 8'h00;
    accept_pend = 1'b0;
    stall_exp = 0;
  endtask

  // Called mid-cycle (just after a posedge): reset pulse lands entirely between edges.
  task automatic reset_pulse();
    up_valid = 1'b0;
    dn_ready = 1'b0;
    accept_pend = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pulse_dn_valid", dn_valid, 0);
    chk("rst_pulse_up_ready", up_ready, 1);
    chk("rst_pulse_dn_data", dn_data, 0);
    chk("rst_pulse_stall", stall_cnt, 0);
    chk("rst_pulse_w1", {dn_valid1, up_ready1, dn_data1}, 3'b010);
    clear_model();
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compares outputs against the model mid-cycle and retires delivered words.
  always @(negedge clk) begin
    logic       exp_v;
    logic [7:0] exp_d;
    if (rst_n) begin
      exp_v = (exp_q.size() > 0);
      exp_d = exp_v ? exp_q[0] : last_out;
      chk("dn_valid", dn_valid, exp_v);
      chk("up_ready", up_ready, exp_q.size() < 2);
      chk("dn_data", dn_data, exp_d);
      chk("w1_out", {dn_valid1, up_ready1, dn_data1}, {exp_v, exp_q.size() < 2, exp_d[0]});
      chk("stall_cnt", stall_cnt, stall_model());
      chk("stall_cnt_w1", stall_cnt1, stall_model());
      if (exp_v && !dn_ready && stall_exp < 32'hFFFF) stall_exp++;
      if (exp_v && dn_ready) begin
        last_out = exp_q.pop_front();
        n_out++;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int base;
    int tries;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      up_valid = 1'($urandom_range(0, 1));
      up_data  = 8'($urandom);
      dn_ready = 1'($urandom_range(0, 1));
      #2;
      chk("reset_dn_valid", dn_valid, 0);
      chk("reset_up_ready", up_ready, 1);
      chk("reset_dn_data", dn_data, 0);
      chk("reset_stall", stall_cnt, 0);
    end
    up_valid = 1'b0;
    dn_ready = 1'b0;
    #1 rst_n = 1'b1;

    // Streaming 0x01..0x10 with dn_ready held high
    base = n_out;
    for (int i = 1; i <= 16; i++) cycle(1'b1, 8'(i), 1'b1, acc);
    idle(3, 1'b1);
    chk("stream_count", n_out - base, 16);
    chk("stream_last", last_out, 8'h10);

    // Back-pressure: A5, 5A fill the buffer, FF must wait
    cycle(1'b1, 8'hA5, 1'b0, acc);
    cycle(1'b1, 8'h5A, 1'b0, acc);
    cycle(1'b1, 8'hFF, 1'b0, acc);
    chk("bp_ff_refused", acc, 0);
    cycle(1'b1, 8'hFF, 1'b0, acc);
    #2;
    chk("bp_full_up_ready", up_ready, 0);
    chk("bp_hold_data", dn_data, 8'hA5);
    base = n_out;
    tries = 0;
    do begin
      cycle(1'b1, 8'hFF, 1'b1, acc);
      tries++;
    end while (!acc && tries < 10);
    chk("bp_ff_accepted", acc, 1);
    idle(4, 1'b1);
    chk("bp_drain_count", n_out - base, 3);
    chk("bp_drain_last", last_out, 8'hFF);

    // Random traffic
    base = n_out;
    for (int i = 0; i < 10000; i++) begin
      cycle(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0), acc);
    end
    idle(4, 1'b1);
    chk("rand_drained_valid", dn_valid, 0);
    chk("rand_progress", (n_out - base) > 1000, 1);

    // Mid-operation reset from FULL, then no stale word may appear
    cycle(1'b1, 8'h11, 1'b0, acc);
    cycle(1'b1, 8'h22, 1'b0, acc);
    cycle(1'b0, 8'h00, 1'b0, acc);
    #2;
    chk("midrst_full", {dn_valid, up_ready}, 2'b10);
    reset_pulse();
    idle(5, 1'b1);

    // Stall statistics: one word held for 20 back-pressured edges
    cycle(1'b0, 8'h00, 1'b0, acc);
    reset_pulse();
    cycle(1'b1, 8'h3C, 1'b0, acc);
    idle(21, 1'b0);
    #2;
`ifdef SKID_STATS_EN
    chk("stats_20", stall_cnt, 20);
`else
    chk("stats_off", stall_cnt, 0);
`endif
    chk("stats_hold_data", dn_data, 8'h3C);
    idle(3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
